// File: rtl/uart_pkg.sv
// Shared UART types and constants: FSM state encoding, oversampling ratio,
// mid-bit sample point and a counter-width helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int OVS = 16;
  localparam int MID = 8;

  // Bits needed to count 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO for the UART transmit path; pointers carry an extra wrap bit
// so full and empty are distinguished without a separate count.
module uart_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push on full still lands.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex UART: shared 16x oversample tick, FIFO-fed transmitter and a
// mid-bit sampling receiver with a holding register. Define UART_PARITY_EN for a parity bit.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int TX_DEPTH   = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [15:0]       BaudDiv,
  input  logic              Rx,
  output logic              Tx,
  input  logic [DATA_W-1:0] TxData,
  input  logic              TxValid,
  output logic              TxReady,
  output logic              TxBusy,
  output logic [DATA_W-1:0] RxData,
  output logic              RxValid,
  input  logic              RxReady,
  output logic              RxFrameErr,
  output logic              RxOverrun,
  output logic              RxParityErr
);

  localparam int BIT_W = cnt_w(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic PAR_ODD = (PARITY_ODD != 0);

  // ---------------- oversample tick ----------------
  logic [15:0] div_q;
  logic [15:0] tick_cnt;
  logic        tick;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      div_q    <= '0;
      tick_cnt <= '0;
    end else if (div_q == '0 || tick_cnt == div_q - 16'd1) begin
      div_q    <= BaudDiv;
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 16'd1;
    end
  end

  assign tick = (div_q != '0) && (tick_cnt == div_q - 16'd1);

  // ---------------- transmit ----------------
  uart_state_e       tx_state, tx_state_n;
  logic [3:0]        tx_ovs, tx_ovs_n;
  logic [BIT_W-1:0]  tx_bit, tx_bit_n;
  logic              tx_stop, tx_stop_n;
  logic [DATA_W-1:0] tx_shift, tx_shift_n;
  logic              tx_par, tx_par_n;
  logic              tx_line_n;
  logic              tx_load;
  logic              tx_bit_end;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;

  uart_sync_fifo #(
    .W     (DATA_W),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (Clk),
    .rst   (Rst),
    .push  (TxValid),
    .din   (TxData),
    .pop   (tx_load),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign TxReady    = !fifo_full;
  assign TxBusy     = (tx_state != IDLE) || !fifo_empty;
  assign tx_bit_end = tick && (tx_ovs == 4'(OVS - 1));

  always_comb begin
    tx_state_n = tx_state;
    tx_ovs_n   = tx_ovs;
    tx_bit_n   = tx_bit;
    tx_stop_n  = tx_stop;
    tx_shift_n = tx_shift;
    tx_par_n   = tx_par;
    tx_load    = 1'b0;
    if (tick && tx_state != IDLE) tx_ovs_n = tx_ovs + 4'd1;
    case (tx_state)
      IDLE:   if (tick && !fifo_empty) tx_load = 1'b1;
      START:  if (tx_bit_end) begin
                tx_state_n = DATA;
                tx_bit_n   = '0;
              end
      DATA:   if (tx_bit_end) begin
                tx_shift_n = tx_shift >> 1;
                if (tx_bit == LAST_BIT) begin
                  tx_stop_n = 1'b0;
`ifdef UART_PARITY_EN
                  tx_state_n = PARITY;
`else
                  tx_state_n = STOP;
`endif
                end else begin
                  tx_bit_n = tx_bit + BIT_W'(1);
                end
              end
      PARITY: if (tx_bit_end) begin
                tx_state_n = STOP;
                tx_stop_n  = 1'b0;
              end
      STOP:   if (tx_bit_end) begin
                if (tx_stop == 1'(STOP_BITS - 1)) begin
                  // Chain straight into the next start bit when more data is queued.
                  if (!fifo_empty) tx_load = 1'b1;
                  else             tx_state_n = IDLE;
                end else begin
                  tx_stop_n = 1'b1;
                end
              end
      default: tx_state_n = IDLE;
    endcase
    if (tx_load) begin
      tx_state_n = START;
      tx_ovs_n   = '0;
      tx_shift_n = fifo_dout;
      tx_par_n   = (^fifo_dout) ^ PAR_ODD;
    end
  end

  always_comb begin
    tx_line_n = 1'b1;
    case (tx_state_n)
      START:   tx_line_n = 1'b0;
      DATA:    tx_line_n = tx_shift_n[0];
      PARITY:  tx_line_n = tx_par_n;
      default: tx_line_n = 1'b1;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      tx_state <= IDLE;
      tx_ovs   <= '0;
      tx_bit   <= '0;
      tx_stop  <= 1'b0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      Tx       <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_ovs   <= tx_ovs_n;
      tx_bit   <= tx_bit_n;
      tx_stop  <= tx_stop_n;
      tx_shift <= tx_shift_n;
      tx_par   <= tx_par_n;
      Tx       <= tx_line_n;
    end
  end

  // ---------------- receive ----------------
  logic              rx_meta, rx_s, rx_prev;
  uart_state_e       rx_state, rx_state_n;
  logic [3:0]        rx_ovs, rx_ovs_n;
  logic [BIT_W-1:0]  rx_bit, rx_bit_n;
  logic [DATA_W-1:0] rx_shift, rx_shift_n;
  logic              rx_wait, rx_wait_n;
  logic              rx_par_bad, rx_par_bad_n;
  logic              rx_done;
  logic              rx_ferr;
  logic              rx_bit_end;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= Rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign rx_bit_end = tick && (rx_ovs == 4'(OVS - 1));

  always_comb begin
    rx_state_n   = rx_state;
    rx_ovs_n     = rx_ovs;
    rx_bit_n     = rx_bit;
    rx_shift_n   = rx_shift;
    rx_wait_n    = rx_wait;
    rx_par_bad_n = rx_par_bad;
    rx_done      = 1'b0;
    rx_ferr      = 1'b0;
    if (tick && rx_state != IDLE) rx_ovs_n = rx_ovs + 4'd1;
    case (rx_state)
      IDLE:   if (rx_prev && !rx_s) begin
                rx_state_n   = START;
                rx_ovs_n     = '0;
                rx_par_bad_n = 1'b0;
              end
      START:  if (tick && rx_ovs == 4'(MID - 1)) begin
                if (rx_s) begin
                  rx_state_n = IDLE;
                end else begin
                  rx_state_n = DATA;
                  rx_ovs_n   = '0;
                  rx_bit_n   = '0;
                end
              end
      DATA:   if (rx_bit_end) begin
                rx_shift_n = {rx_s, rx_shift[DATA_W-1:1]};
                if (rx_bit == LAST_BIT) begin
                  rx_wait_n = 1'b0;
`ifdef UART_PARITY_EN
                  rx_state_n = PARITY;
`else
                  rx_state_n = STOP;
`endif
                end else begin
                  rx_bit_n = rx_bit + BIT_W'(1);
                end
              end
      PARITY: if (rx_bit_end) begin
                rx_par_bad_n = rx_s != ((^rx_shift) ^ PAR_ODD);
                rx_state_n   = STOP;
              end
      STOP:   if (rx_wait) begin
                // Broken frame: hold off until the line returns high.
                if (rx_s) begin
                  rx_wait_n  = 1'b0;
                  rx_state_n = IDLE;
                end
              end else if (rx_bit_end) begin
                if (rx_s) begin
                  rx_done    = 1'b1;
                  rx_state_n = IDLE;
                end else begin
                  rx_ferr   = 1'b1;
                  rx_wait_n = 1'b1;
                end
              end
      default: rx_state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      rx_state   <= IDLE;
      rx_ovs     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      rx_wait    <= 1'b0;
      rx_par_bad <= 1'b0;
    end else begin
      rx_state   <= rx_state_n;
      rx_ovs     <= rx_ovs_n;
      rx_bit     <= rx_bit_n;
      rx_shift   <= rx_shift_n;
      rx_wait    <= rx_wait_n;
      rx_par_bad <= rx_par_bad_n;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      RxData     <= '0;
      RxValid    <= 1'b0;
      RxFrameErr <= 1'b0;
      RxOverrun  <= 1'b0;
    end else begin
      RxFrameErr <= rx_ferr;
      RxOverrun  <= 1'b0;
      if (rx_done) begin
        if (!RxValid || RxReady) begin
          RxData  <= rx_shift;
          RxValid <= 1'b1;
        end else begin
          RxOverrun <= 1'b1;
        end
      end else if (RxReady) begin
        RxValid <= 1'b0;
      end
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge Clk) begin
    if (Rst) RxParityErr <= 1'b0;
    else     RxParityErr <= rx_done && rx_par_bad;
  end
`else
  assign RxParityErr = 1'b0;
`endif

endmodule

// File: tb/tb_uart_transceiver.sv
// Self-checking bench for uart_transceiver: frame-level TX monitor and RX word
// scoreboard built from the serial frame format, plus directed literal checks.
module tb_uart_transceiver;

  localparam int DATA_W     = 8;
  localparam int STOP_BITS  = 1;
  localparam int PARITY_ODD = 0;
`ifdef UART_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int FRAME_BITS = 1 + DATA_W + PAR_BITS + STOP_BITS;

  logic              Clk;
  logic              Rst;
  logic [15:0]       BaudDiv;
  logic              Rx;
  logic              Tx;
  logic [DATA_W-1:0] TxData;
  logic              TxValid;
  logic              TxReady;
  logic              TxBusy;
  logic [DATA_W-1:0] RxData;
  logic              RxValid;
  logic              RxReady;
  logic              RxFrameErr;
  logic              RxOverrun;
  logic              RxParityErr;

  uart_transceiver #(
    .DATA_W     (DATA_W),
    .TX_DEPTH   (16),
    .STOP_BITS  (STOP_BITS),
    .PARITY_ODD (PARITY_ODD)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .BaudDiv     (BaudDiv),
    .Rx          (Rx),
    .Tx          (Tx),
    .TxData      (TxData),
    .TxValid     (TxValid),
    .TxReady     (TxReady),
    .TxBusy      (TxBusy),
    .RxData      (RxData),
    .RxValid     (RxValid),
    .RxReady     (RxReady),
    .RxFrameErr  (RxFrameErr),
    .RxOverrun   (RxOverrun),
    .RxParityErr (RxParityErr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int baud     = 4;

  logic [DATA_W-1:0] tx_exp_q[$];
  logic [DATA_W-1:0] rx_exp_q[$];
  int                start_log[$];
  logic              in_frame = 1'b0;
  logic [15:0]       last_frame = '0;
  int                n_ferr = 0;
  int                n_ovr  = 0;
  int                n_perr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic exp_bit(input logic [DATA_W-1:0] w, input int i);
    if (i == 0) return 1'b0;
    if (i <= DATA_W) return w[i-1];
    if (PAR_BITS == 1 && i == DATA_W + 1) return (^w) ^ (PARITY_ODD != 0);
    return 1'b1;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge Clk);
      cyc++;
    end
  end

  // TX monitor: every cycle of a frame must carry the expected bit.
  initial begin
    logic [DATA_W-1:0] cur_word;
    logic tx_prev;
    int fcyc, bad_cnt, bi, bc;
    tx_prev = 1'b1;
    fcyc = 0;
    bad_cnt = 0;
    cur_word = '0;
    forever begin
      @(negedge Clk);
      bc = 16 * baud;
      if (Rst) begin
        in_frame = 1'b0;
        tx_exp_q.delete();
        tx_prev = 1'b1;
      end else begin
        if (!in_frame && tx_prev && !Tx) begin
          if (tx_exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL tx_unexpected_frame: start bit at cycle %0d, expected none", cyc);
          end else begin
            cur_word = tx_exp_q.pop_front();
            in_frame = 1'b1;
            fcyc = 0;
            bad_cnt = 0;
            last_frame = '0;
            start_log.push_back(cyc);
          end
        end
        if (in_frame) begin
          bi = fcyc / bc;
          if (Tx !== exp_bit(cur_word, bi)) bad_cnt++;
          if (fcyc % bc == bc / 2) last_frame[bi] = Tx;
          fcyc++;
          if (fcyc % bc == 0) begin
            check($sformatf("tx_bit%0d_wrong_cycles", bi), bad_cnt, 0);
            bad_cnt = 0;
            if (fcyc == FRAME_BITS * bc) in_frame = 1'b0;
          end
        end
        tx_prev = Tx;
      end
    end
  end

  // RX scoreboard: each consumed word must be the next expected one.
  initial begin
    forever begin
      @(negedge Clk);
      if (Rst) begin
        rx_exp_q.delete();
      end else begin
        if (RxValid && RxReady) begin
          if (rx_exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rx_unexpected_word: got %0h, expected none", RxData);
          end else begin
            check("rx_data", RxData, rx_exp_q.pop_front());
          end
        end
        if (RxFrameErr)  n_ferr++;
        if (RxOverrun)   n_ovr++;
        if (RxParityErr) n_perr++;
      end
    end
  end

  initial begin
    repeat (90000) @(posedge Clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic push_word(input logic [DATA_W-1:0] w);
    int k;
    k = 0;
    while (!TxReady && k < 20000) begin
      step(1);
      k++;
    end
    if (!TxReady) begin
      n_checks++;
      n_fail++;
      $display("FAIL tx_ready_timeout: got 0, expected 1");
    end
    TxData  = w;
    TxValid = 1'b1;
    step(1);
    TxValid = 1'b0;
    tx_exp_q.push_back(w);
  endtask

  task automatic wait_tx_idle(input int budget);
    int k;
    k = 0;
    while ((TxBusy || in_frame) && k < budget) begin
      step(1);
      k++;
    end
    if (TxBusy || in_frame) begin
      n_checks++;
      n_fail++;
      $display("FAIL tx_idle_timeout: got busy, expected idle within %0d cycles", budget);
    end
    step(4);
  endtask

  task automatic send_rx(input logic [DATA_W-1:0] w, input logic stop_val, input logic par_flip);
    int bc;
    bc = 16 * baud;
    if (stop_val) rx_exp_q.push_back(w);
    Rx = 1'b0;
    step(bc);
    for (int i = 0; i < DATA_W; i++) begin
      Rx = w[i];
      step(bc);
    end
    if (PAR_BITS == 1) begin
      Rx = (^w) ^ (PARITY_ODD != 0) ^ par_flip;
      step(bc);
    end
    Rx = stop_val;
    step(bc);
    Rx = 1'b1;
    step(bc);
  endtask

  initial begin
    int bc, n0, e0, o0, p0;
    logic [DATA_W-1:0] w;
    Rst = 1'b1;
    BaudDiv = '0;
    Rx = 1'b1;
    TxData = '0;
    TxValid = 1'b0;
    RxReady = 1'b1;
    step(3);
    check("rst_tx", Tx, 1);
    check("rst_txready", TxReady, 1);
    check("rst_txbusy", TxBusy, 0);
    check("rst_rxvalid", RxValid, 0);
    check("rst_rxdata", RxData, 0);
    check("rst_flags", {RxFrameErr, RxOverrun, RxParityErr}, 0);
    Rst = 1'b0;
    step(2);

    // Single 0x55 frame, bit pattern pinned by hand.
    baud = 20;
    BaudDiv = 16'd20;
    step(2);
    push_word(8'h55);
    wait_tx_idle(8000);
    check("tx55_frames", start_log.size(), 1);
`ifdef UART_PARITY_EN
    check("tx55_pattern", last_frame, 16'h04AA);
`else
    check("tx55_pattern", last_frame, 16'h02AA);
`endif

    // Fill FIFO with ticks stopped, then release and expect gapless frames.
    BaudDiv = '0;
    step(50);
    start_log.delete();
    for (int i = 0; i < 16; i++) begin
      TxData = 8'(8'h10 + i * 7);
      TxValid = 1'b1;
      step(1);
      tx_exp_q.push_back(TxData);
    end
    TxValid = 1'b0;
    check("full_txready", TxReady, 0);
    TxData = 8'hEE;
    TxValid = 1'b1;
    step(1);
    TxValid = 1'b0;
    step(100);
    check("no_tick_no_frame", start_log.size(), 0);
    check("full_txbusy", TxBusy, 1);
    baud = 4;
    BaudDiv = 16'd4;
    wait_tx_idle(16 * FRAME_BITS * 64 + 2000);
    check("burst_frames", start_log.size(), 16);
    for (int i = 1; i < start_log.size(); i++)
      check("burst_gap", start_log[i] - start_log[i-1], FRAME_BITS * 64);
    check("burst_left", tx_exp_q.size(), 0);

    // Receive with holding register and overrun.
    baud = 8;
    BaudDiv = 16'd8;
    step(20);
    RxReady = 1'b0;
    send_rx(8'hA3, 1'b1, 1'b0);
    check("rx_a3_valid", RxValid, 1);
    check("rx_a3_data", RxData, 8'hA3);
    o0 = n_ovr;
    send_rx(8'h5C, 1'b0, 1'b0);
    rx_exp_q.delete();
    rx_exp_q.push_back(8'hA3);
    n_ferr = 0;
    // Second frame above used a bad stop; redo with a good one for the overrun.
    send_rx(8'h5C, 1'b1, 1'b0);
    void'(rx_exp_q.pop_back());
    check("rx_overrun_pulses", n_ovr - o0, 1);
    check("rx_overrun_keep", RxData, 8'hA3);
    check("rx_overrun_valid", RxValid, 1);
    RxReady = 1'b1;
    step(2);
    check("rx_consumed", RxValid, 0);

    // Short low glitch: nothing reported.
    e0 = n_ferr; o0 = n_ovr; p0 = n_perr;
    Rx = 1'b0;
    step(4 * baud);
    Rx = 1'b1;
    step(32 * baud);
    check("glitch_valid", RxValid, 0);
    check("glitch_flags", (n_ferr - e0) + (n_ovr - o0) + (n_perr - p0), 0);

    // Stop bit low: framing error, word dropped.
    send_rx(8'h3C, 1'b0, 1'b0);
    step(4);
    check("ferr_pulses", n_ferr - e0, 1);
    check("ferr_valid", RxValid, 0);

`ifdef UART_PARITY_EN
    push_word(8'h07);
    wait_tx_idle(4000);
    check("tx07_parity_bit", last_frame[9], 1);
    p0 = n_perr;
    send_rx(8'h81, 1'b1, 1'b1);
    step(4);
    check("perr_pulses", n_perr - p0, 1);
    check("perr_word_kept", rx_exp_q.size(), 0);
`endif

    // Randomised full-duplex rounds.
    for (int r = 0; r < 3; r++) begin
      baud = int'($urandom_range(4, 7));
      BaudDiv = 16'(baud);
      step(25);
      e0 = n_ferr; o0 = n_ovr; p0 = n_perr;
      fork
        begin
          for (int i = 0; i < 4; i++) begin
            step(int'($urandom_range(1, 300)));
            push_word(8'($urandom));
          end
        end
        begin
          for (int i = 0; i < 4; i++) begin
            w = 8'($urandom);
            send_rx(w, 1'b1, 1'b0);
          end
        end
      join
      wait_tx_idle(8 * FRAME_BITS * 16 * baud + 1000);
      check("rand_tx_left", tx_exp_q.size(), 0);
      check("rand_rx_left", rx_exp_q.size(), 0);
      check("rand_flags", (n_ferr - e0) + (n_ovr - o0) + (n_perr - p0), 0);
    end

    // Reset in the middle of a TX frame and an RX frame.
    baud = 4;
    BaudDiv = 16'd4;
    bc = 64;
    step(20);
    RxReady = 1'b0;
    send_rx(8'h11, 1'b1, 1'b0);
    check("pre_rst_rxvalid", RxValid, 1);
    push_word(8'h96);
    push_word(8'h69);
    Rx = 1'b0;
    step(3 * bc);
    Rst = 1'b1;
    step(1);
    check("mid_rst_tx", Tx, 1);
    check("mid_rst_txbusy", TxBusy, 0);
    check("mid_rst_txready", TxReady, 1);
    check("mid_rst_rxvalid", RxValid, 0);
    Rst = 1'b0;
    Rx = 1'b1;
    RxReady = 1'b1;
    n0 = start_log.size();
    step(3 * bc);
    check("post_rst_no_frame", start_log.size() - n0, 0);
    check("post_rst_idle", TxBusy, 0);
    fork
      push_word(8'hC5);
      send_rx(8'h3A, 1'b1, 1'b0);
    join
    wait_tx_idle(FRAME_BITS * bc + 2000);
    check("post_rst_tx_frames", start_log.size() - n0, 1);
    check("post_rst_rx_left", rx_exp_q.size(), 0);
    check("post_rst_tx_left", tx_exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
